// File: rtl/block_data_memory.sv
// -----------------------------------------------------------------------------
// block_data_memory
//
// Main-memory responder on the data-cache miss path. It serves one 128-bit
// block read or write-back at a time with a fixed multi-cycle latency, stalling
// the cache through mem_busywait. It stands in for off-chip DRAM in the
// pipeline testbench.
//
// Parameters:
//   ADDR_BITS : low block-address bits that index storage (2**ADDR_BITS blocks)
//   LATENCY   : ACCESS-state cycles per request, legal range 1..15
//
// Ports:
//   clock         in   1    system clock, all state on posedge
//   reset         in   1    synchronous, active-high
//   mem_read      in   1    block read request, held until busywait low
//   mem_write     in   1    block write request, held until busywait low
//   mem_address   in   28   block address (byte address [31:4])
//   mem_writedata in   128  block to write
//   mem_readdata  out  128  last completed read, held until the next one
//   mem_busywait  out  1    stall to the cache (combinational)
//
// Build option:
//   DMEM_RESET_CLEAR_EN : when defined, reset also zeroes every storage entry.
// -----------------------------------------------------------------------------
module block_data_memory #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_address,
    input  logic [127:0] mem_writedata,
    output logic [127:0] mem_readdata,
    output logic         mem_busywait
);

    localparam int         DEPTH = 2 ** ADDR_BITS;
    // Counter starts at LATENCY-1 so the access lands on the LATENCY-th
    // ACCESS cycle.
    localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    state_e                 state_q;
    logic [3:0]             count_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   write_q;
    logic [127:0]           wdata_q;
    logic [127:0]           rdata_q;
    logic [127:0]           mem_q [DEPTH];
    logic                   mem_we;

    // Upper block-address bits are intentionally ignored, so addresses alias.
    logic unused_addr;
    assign unused_addr = ^mem_address[27:ADDR_BITS];

    // Control FSM. Request fields are captured once in IDLE so that input
    // changes during ACCESS cannot affect the transfer.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        addr_q  <= mem_address[ADDR_BITS-1:0];
                        wdata_q <= mem_writedata;
                        write_q <= mem_write;  // write wins when both are high
                        count_q <= LOAD;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count_q != 4'd0) begin
                        count_q <= count_q - 4'd1;
                    end else begin
                        if (!write_q) begin
                            rdata_q <= mem_q[addr_q];
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Requests seen here are not accepted; the cache re-presents
                    // them in the following IDLE cycle.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Commit a write on the final ACCESS edge; a reset on that edge aborts it.
    assign mem_we = !reset && (state_q == ACCESS) && (count_q == 4'd0) && write_q;

`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end
`else
    // NOTE: storage has no reset so it maps onto plain RAM; contents are
    // undefined until written and survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end
`endif

    // Busywait rises in the same cycle a request appears in IDLE, so the cache
    // never sees a zero-latency completion.
    assign mem_busywait = ((state_q == IDLE) && (mem_read || mem_write)) ||
                          (state_q == ACCESS);
    assign mem_readdata = rdata_q;

endmodule

// File: tb/tb_block_data_memory.sv
// -----------------------------------------------------------------------------
// tb_block_data_memory
//
// Self-checking bench for block_data_memory. Drives a LATENCY=5 instance for
// the main tests and a LATENCY=1 instance for the short-latency case. Expected
// values come from a directed table and from a block-level reference model
// (an array of blocks plus the last read result).
// -----------------------------------------------------------------------------
module tb_block_data_memory;

    localparam int TB_LAT = 5;

    logic         clock;
    logic         reset;
    logic         mem_read, mem_write;
    logic         d1_read, d1_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata, d1_readdata;
    logic         mem_busywait, d1_busywait;

    block_data_memory #(.ADDR_BITS(8), .LATENCY(TB_LAT)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    block_data_memory #(.ADDR_BITS(8), .LATENCY(1)) dut_l1 (
        .clock        (clock),
        .reset        (reset),
        .mem_read     (d1_read),
        .mem_write    (d1_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (d1_readdata),
        .mem_busywait (d1_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: block storage indexed by the low 8 address bits.
    logic [127:0] m_mem   [256];
    bit           m_known [256];
    logic [127:0] m_rdata;

    typedef struct {
        bit           wr;
        bit           rd;
        logic [27:0]  addr;
        logic [127:0] data;
        logic [127:0] exp_rd;
        bit           hold;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit busy_of(input bit sel);
        return sel ? d1_busywait : mem_busywait;
    endfunction

    function automatic logic [127:0] rdata_of(input bit sel);
        return sel ? d1_readdata : mem_readdata;
    endfunction

    task automatic drive(input bit sel, input bit wr, input bit rd);
        if (sel) begin
            d1_write = wr;
            d1_read  = rd;
        end else begin
            mem_write = wr;
            mem_read  = rd;
        end
    endtask

    // Clears the model the way a reset does.
    task automatic model_reset();
        m_rdata = '0;
`ifdef DMEM_RESET_CLEAR_EN
        for (int i = 0; i < 256; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b1;
        end
`endif
    endtask

    // Presents one request at the next negedge, counts busywait-high cycles,
    // checks the count and read data in the first low cycle, then releases.
    task automatic run_req(input bit sel, input bit wr, input bit rd,
                           input logic [27:0] addr, input logic [127:0] data,
                           input int exp_busy, input logic [127:0] exp_rd,
                           input bit scramble, input bit hold, input string name);
        int cnt;
        bit b;
        @(negedge clock);
        mem_address   = addr;
        mem_writedata = data;
        drive(sel, wr, rd);
        cnt = 0;
        #1 b = busy_of(sel);
        while (b && cnt < 40) begin
            cnt++;
            @(negedge clock);
            if (scramble) begin
                mem_address   = 28'($urandom);
                mem_writedata = rand128();
            end
            #1 b = busy_of(sel);
        end
        check({name, " busy cycles"}, 128'(cnt), 128'(exp_busy));
        check({name, " rdata"}, rdata_of(sel), exp_rd);
        drive(sel, 1'b0, 1'b0);
        if (hold) begin
            @(negedge clock);
            #1;
            check({name, " rdata held"}, rdata_of(sel), exp_rd);
            check({name, " idle busy"}, 128'(busy_of(sel)), 128'(0));
        end
    endtask

    initial begin
        int cnt;
        bit b;
        logic [27:0]  a;
        logic [127:0] d;
        bit wr, rd;
        logic [127:0] exp;

        vecs[0] = '{1, 0, 28'h05, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 128'h0, 1};
        vecs[1] = '{0, 1, 28'h05, 128'h0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1};
        vecs[2] = '{1, 0, 28'h105, {16{8'hAA}}, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1};
        vecs[3] = '{0, 1, 28'h005, 128'h0, {16{8'hAA}}, 1};
        vecs[4] = '{1, 0, 28'h20, {16{8'h20}}, {16{8'hAA}}, 1};
        vecs[5] = '{1, 0, 28'h10, {16{8'h10}}, {16{8'hAA}}, 0};
        vecs[6] = '{0, 1, 28'h20, 128'h0, {16{8'h20}}, 1};
        vecs[7] = '{1, 1, 28'h30, {16{8'h33}}, {16{8'h20}}, 1};
        vecs[8] = '{0, 1, 28'h30, 128'h0, {16{8'h33}}, 1};

        for (int i = 0; i < 256; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = 'x;
        end
        m_rdata = '0;

        mem_read = 0; mem_write = 0; d1_read = 0; d1_write = 0;
        mem_address = '0; mem_writedata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset rdata", mem_readdata, 128'h0);
        check("reset busy", 128'(mem_busywait), 128'(0));
        check("reset l1 rdata", d1_readdata, 128'h0);

        // Directed table on the LATENCY=5 instance; entry 5 to 6 is back-to-back.
        for (int i = 0; i < 9; i++) begin
            run_req(0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data,
                    TB_LAT + 1, vecs[i].exp_rd, 0, vecs[i].hold, $sformatf("vec%0d", i));
            if (vecs[i].wr) begin
                m_mem[vecs[i].addr[7:0]]   = vecs[i].data;
                m_known[vecs[i].addr[7:0]] = 1'b1;
            end else begin
                m_rdata = vecs[i].exp_rd;
            end
        end

        // LATENCY=1 instance: busywait high for exactly two cycles.
        run_req(1, 1, 0, 28'h02, 128'h1, 2, 128'h0, 0, 1, "l1 write");
        run_req(1, 0, 1, 28'h02, 128'h0, 2, 128'h1, 0, 1, "l1 read");

        // Reset in the third ACCESS cycle of a write aborts it.
        run_req(0, 1, 0, 28'h07, 128'h11, TB_LAT + 1, m_rdata, 0, 1, "pre rst write");
        m_mem[7] = 128'h11; m_known[7] = 1'b1;
        @(negedge clock);
        mem_address = 28'h07; mem_writedata = 128'h22; mem_write = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1; mem_write = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        check("mid rst rdata", mem_readdata, 128'h0);
        check("mid rst busy", 128'(mem_busywait), 128'(0));
`ifdef DMEM_RESET_CLEAR_EN
        exp = 128'h0;
`else
        exp = 128'h11;
`endif
        run_req(0, 0, 1, 28'h07, 128'h0, TB_LAT + 1, exp, 0, 1, "aborted write");
        m_rdata = exp;

        // A request still held across reset restarts the full latency.
        @(negedge clock);
        mem_address = 28'h05; mem_read = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        cnt = 0;
        #1 b = mem_busywait;
        while (b && cnt < 40) begin
            cnt++;
            @(negedge clock);
            #1 b = mem_busywait;
        end
        mem_read = 1'b0;
        check("restart busy cycles", 128'(cnt), 128'(TB_LAT + 1));
        m_rdata = m_mem[5];
        check("restart rdata", mem_readdata, m_rdata);

        // Array clear on reset (optional build) versus retention (default).
        run_req(0, 1, 0, 28'h03, 128'h5, TB_LAT + 1, m_rdata, 0, 1, "clr write");
        m_mem[3] = 128'h5; m_known[3] = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
`ifdef DMEM_RESET_CLEAR_EN
        exp = 128'h0;
`else
        exp = 128'h5;
`endif
        run_req(0, 0, 1, 28'h03, 128'h0, TB_LAT + 1, exp, 0, 1, "clr read");
        m_rdata = exp;

        // Random traffic, inputs scrambled during ACCESS, upper bits aliased.
        for (int i = 0; i < 30; i++) begin
            a  = {20'($urandom), 8'($urandom_range(0, 15))};
            d  = rand128();
            wr = 1'($urandom);
            if (!wr && !m_known[a[7:0]]) wr = 1'b1;
            rd = wr ? 1'($urandom) : 1'b1;
            if (wr) begin
                m_mem[a[7:0]]   = d;
                m_known[a[7:0]] = 1'b1;
            end else begin
                m_rdata = m_mem[a[7:0]];
            end
            run_req(0, wr, rd, a, d, TB_LAT + 1, m_rdata, 1, 1'($urandom),
                    $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
